// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding codes, FSM states and shadow-stage record for the hazard unit
package hazard_pkg;
  localparam int HZ_REG_W = 5;
  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_EX  = 2'b01;
  localparam logic [1:0] FW_MEM = 2'b10;
  localparam logic [1:0] FW_WB  = 2'b11;
  typedef enum logic {HZ_RUN, HZ_STALL} hz_state_t;
  typedef struct packed {
    logic [HZ_REG_W-1:0] rd;
    logic                rf_le;
    logic                load;
  } stage_info_t;
endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// hazard_forwarding_unit_if: ID-stage operands in, forwarding/stall/flush controls and counters out
interface hazard_forwarding_unit_if #(parameter int REG_W = 5, parameter int CNT_W = 16);
  logic [REG_W-1:0] ra_id, rb_id, rd_id;
  logic             use_ra_id, use_rb_id, rf_le_id, load_id, jump_ex;
  logic [1:0]       fw_a_sel, fw_b_sel;
  logic             cu_nop, pc_le, if_id_le, if_id_clr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output ra_id, rb_id, rd_id, use_ra_id, use_rb_id, rf_le_id, load_id, jump_ex,
    input  fw_a_sel, fw_b_sel, cu_nop, pc_le, if_id_le, if_id_clr, stall_cnt, flush_cnt
  );
  modport slave (
    input  ra_id, rb_id, rd_id, use_ra_id, use_rb_id, rf_le_id, load_id, jump_ex,
    output fw_a_sel, fw_b_sel, cu_nop, pc_le, if_id_le, if_id_clr, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_forwarding_unit_fw_select.sv
// fw_select: priority encoder choosing the youngest shadow stage that writes one ID source operand
module fw_select import hazard_pkg::*; #(parameter int REG_W = 5) (
  input  logic [REG_W-1:0] r,
  input  logic             use_r,
  input  stage_info_t      ex,
  input  stage_info_t      mem,
  input  stage_info_t      wb,
  output logic [1:0]       sel,
  output logic             ex_hit
);
  logic valid, mem_hit, wb_hit;
  always_comb begin
    valid   = use_r && (r != '0);
    ex_hit  = valid && ex.rf_le  && (ex.rd  == HZ_REG_W'(r));
    mem_hit = valid && mem.rf_le && (mem.rd == HZ_REG_W'(r));
    wb_hit  = valid && wb.rf_le  && (wb.rd  == HZ_REG_W'(r));
    sel     = ex_hit ? FW_EX : mem_hit ? FW_MEM : wb_hit ? FW_WB : FW_RF;
  end
endmodule

// File: rtl/hazard_forwarding_unit.sv
// hazard_forwarding_unit: shadow EX/MEM/WB tracking, operand forwarding, load-use stall and jump flush.
// Define HAZARD_CNT_EN to build saturating stall/flush event counters; otherwise they read zero.
module hazard_forwarding_unit import hazard_pkg::*; #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic                     clk,
  input logic                     reset,
  hazard_forwarding_unit_if.slave hz
);
  stage_info_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  hz_state_t   state_q, state_d;
  logic [1:0]  fw_a, fw_b;
  logic        a_ex_hit, b_ex_hit, load_use, stall, cu_nop;
  fw_select #(.REG_W(REG_W)) u_fw_a (
    .r(hz.ra_id), .use_r(hz.use_ra_id), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .sel(fw_a), .ex_hit(a_ex_hit)
  );
  fw_select #(.REG_W(REG_W)) u_fw_b (
    .r(hz.rb_id), .use_r(hz.use_rb_id), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .sel(fw_b), .ex_hit(b_ex_hit)
  );
  // A taken jump wins over a load-use hazard: the dependent ID instruction is flushed anyway.
  always_comb begin
    load_use = (a_ex_hit || b_ex_hit) && ex_q.load;
    stall    = load_use && (state_q == HZ_RUN) && !hz.jump_ex;
    cu_nop   = stall || hz.jump_ex;
    state_d  = stall ? HZ_STALL : HZ_RUN;
    ex_d     = cu_nop ? stage_info_t'('0)
                      : stage_info_t'{HZ_REG_W'(hz.rd_id), hz.rf_le_id, hz.load_id};
    mem_d    = ex_q;
    wb_d     = mem_q;
  end
  assign hz.fw_a_sel  = fw_a;
  assign hz.fw_b_sel  = fw_b;
  assign hz.cu_nop    = cu_nop;
  assign hz.pc_le     = !stall;
  assign hz.if_id_le  = !stall;
  assign hz.if_id_clr = hz.jump_ex;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end
`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall && !(&stall_cnt_q)};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, hz.jump_ex && !(&flush_cnt_q)};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// tb_hazard_forwarding_unit: directed checks of forwarding, load-use stall, flush, reset and counters
module tb_hazard_forwarding_unit;
  localparam int CNT_W = 4;
`ifdef HAZARD_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  hazard_forwarding_unit_if #(.REG_W(5), .CNT_W(CNT_W)) hz();
  hazard_forwarding_unit #(.REG_W(5), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  // {fw_a_sel, fw_b_sel, cu_nop, pc_le, if_id_le, if_id_clr}
  logic [7:0] outs;
  assign outs = {hz.fw_a_sel, hz.fw_b_sel, hz.cu_nop, hz.pc_le, hz.if_id_le, hz.if_id_clr};
  localparam logic [7:0] IDLE = 8'b00_00_0110;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic id(input logic [4:0] ra, input logic [4:0] rb, input logic ua, input logic ub,
                    input logic [4:0] rd, input logic rf, input logic ld, input logic jmp);
    hz.ra_id = ra; hz.rb_id = rb; hz.use_ra_id = ua; hz.use_rb_id = ub;
    hz.rd_id = rd; hz.rf_le_id = rf; hz.load_id = ld; hz.jump_ex = jmp;
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic flush_pipe();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask
  initial begin
    id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_outs", outs, IDLE);
    chk("reset_stall_cnt", 8'(hz.stall_cnt), 8'd0);
    chk("reset_flush_cnt", 8'(hz.flush_cnt), 8'd0);
    // ALU dependency chain on r3
    id(0, 0, 0, 0, 3, 1, 0, 0);
    chk("alu_writer", outs, IDLE);
    tick();
    id(3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_ex", outs, 8'b01_00_0110);
    tick();
    id(3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_mem", outs, 8'b10_00_0110);
    tick();
    id(3, 0, 1, 0, 0, 0, 0, 0);
    chk("fwd_wb", outs, 8'b11_00_0110);
    tick();
    flush_pipe();
    chk("drained", outs, IDLE);
    // load-use on rb=r5
    id(0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    id(0, 5, 0, 1, 0, 0, 0, 0);
    chk("load_use_stall", outs, 8'b00_01_1000);
    tick();
    chk("after_stall_mem", outs, 8'b00_10_0110);
    tick();
    chk("stall_cnt_1", 8'(hz.stall_cnt), 8'(CE));
    flush_pipe();
    // GR0 never forwarded, even from a load
    id(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    id(0, 0, 1, 1, 0, 0, 0, 0);
    chk("gr0_no_fwd", outs, IDLE);
    tick();
    flush_pipe();
    // r7 in EX and WB: EX wins
    id(0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    id(0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    id(7, 7, 1, 1, 0, 0, 0, 0);
    chk("prio_ex_over_wb", outs, 8'b01_01_0110);
    id(7, 7, 0, 1, 0, 0, 0, 0);
    chk("prio_use_ra_off", outs, 8'b00_01_0110);
    flush_pipe();
    // jump together with a load-use hazard on r2
    id(0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    id(2, 0, 1, 0, 0, 0, 0, 1);
    chk("flush_over_hazard", outs, 8'b01_00_1111);
    tick();
    id(2, 0, 1, 0, 0, 0, 0, 0);
    chk("no_stall_after_flush", outs, 8'b10_00_0110);
    chk("flush_cnt_1", 8'(hz.flush_cnt), 8'(CE));
    chk("stall_cnt_kept", 8'(hz.stall_cnt), 8'(CE));
    flush_pipe();
    // reset while in STALL
    id(0, 0, 0, 0, 4, 1, 1, 0);
    tick();
    id(0, 4, 0, 1, 0, 0, 0, 0);
    chk("stall_before_reset", outs, 8'b00_01_1000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_in_stall_outs", outs, IDLE);
    chk("reset_in_stall_scnt", 8'(hz.stall_cnt), 8'd0);
    id(0, 4, 0, 1, 0, 0, 0, 0);
    chk("reset_cleared_shadow", outs, IDLE);
    // 2^CNT_W+3 stalls saturate stall_cnt
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      id(0, 0, 0, 0, 6, 1, 1, 0);
      tick();
      id(0, 6, 0, 1, 0, 0, 0, 0);
      tick();
      tick();
      if (i == 13) chk("stall_cnt_14", 8'(hz.stall_cnt), 8'(14 * CE));
    end
    chk("stall_cnt_sat", 8'(hz.stall_cnt), 8'(CE * ((1 << CNT_W) - 1)));
    chk("flush_cnt_after_reset", 8'(hz.flush_cnt), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
